// File: rtl/rib_arbiter_pkg.sv
// Shared types and constants for the RIB sequencing arbiter.
package rib_arbiter_pkg;

  // Transaction sequencer states, 2-bit encoded.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // Response watchdog counter width and master index width.
  localparam int CNT_W = 8;
  localparam int IDX_W = 2;

  // Saturating increment so the watchdog counter can never wrap back to 0.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rib_rr_pick.sv
// Combinational winner picker: high-priority masters first (lowest index),
// otherwise round-robin search starting at rr_ptr_i.
module rib_rr_pick
  import rib_arbiter_pkg::*;
#(
  parameter int         MASTER_NUM   = 4,
  parameter logic [3:0] HI_PRIO_MASK = 4'b0100
) (
  input  logic [MASTER_NUM-1:0] req_i,
  input  logic [IDX_W-1:0]      rr_ptr_i,
  output logic [MASTER_NUM-1:0] gnt_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  any_o
);

  logic [MASTER_NUM-1:0] hi_req;
  logic                  found;
  int                    pos;
  logic [IDX_W-1:0]      pos_idx;

  assign hi_req = req_i & HI_PRIO_MASK[MASTER_NUM-1:0];
  assign any_o  = |req_i;

  // Priority override first, then a rotating scan from rr_ptr_i.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    if (|hi_req) begin
      for (int i = 0; i < MASTER_NUM; i++) begin
        if (hi_req[i] && !found) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = IDX_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < MASTER_NUM; k++) begin
        pos = int'(rr_ptr_i) + k;
        if (pos >= MASTER_NUM) begin
          pos = pos - MASTER_NUM;
        end
        pos_idx = pos[IDX_W-1:0];
        if (req_i[pos_idx] && !found) begin
          found          = 1'b1;
          gnt_o[pos_idx] = 1'b1;
          idx_o          = pos_idx;
        end
      end
    end
  end

endmodule

// File: rtl/rib_arbiter.sv
// RIB sequencing arbiter: shares one slave request/response channel among
// up to four masters, holding the grant for a full request+response
// transaction, with a response watchdog that turns a hung slave into an
// error response.
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int         MASTER_NUM   = 4,
  parameter logic [3:0] HI_PRIO_MASK = 4'b0100,
  parameter logic [7:0] TIMEOUT      = 8'd255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MASTER_NUM-1:0] m_req_vld_i,
  output logic [MASTER_NUM-1:0] m_req_rdy_o,
  output logic [MASTER_NUM-1:0] m_rsp_vld_o,
  input  logic [MASTER_NUM-1:0] m_rsp_rdy_i,
  output logic                  s_req_vld_o,
  input  logic                  s_req_rdy_i,
  input  logic                  s_rsp_vld_i,
  output logic                  s_rsp_rdy_o,
  output logic [MASTER_NUM-1:0] grant_o,
  output logic [IDX_W-1:0]      grant_idx_o,
  output logic                  err_rsp_o,
  output logic                  bus_err_o,
  output logic [IDX_W-1:0]      err_master_o,
  output logic                  busy_o
);

  state_e                state_q, state_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]      gidx_q, gidx_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      err_master_q, err_master_d;
  logic                  bus_err_q, bus_err_d;

  logic [MASTER_NUM-1:0] pick_gnt;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [IDX_W-1:0]      rr_next;

  logic                  g_req_vld;
  logic                  g_rsp_rdy;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  wd_fire;

  rib_rr_pick #(
    .MASTER_NUM   (MASTER_NUM),
    .HI_PRIO_MASK (HI_PRIO_MASK)
  ) u_pick (
    .req_i    (m_req_vld_i),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (pick_gnt),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Pointer moves to the master after the winner, wrapping at MASTER_NUM.
  assign rr_next = (pick_idx == IDX_W'(MASTER_NUM - 1)) ? '0 : pick_idx + 1'b1;

  // Granted master's own handshake lines.
  assign g_req_vld = m_req_vld_i[gidx_q];
  assign g_rsp_rdy = m_rsp_rdy_i[gidx_q];

  // Watchdog only fires on a silent slave; a valid response in the limit
  // cycle always takes precedence over the error.
  assign cnt_inc = sat_inc(cnt_q);
  assign wd_fire = (TIMEOUT != 8'd0) && !s_rsp_vld_i && (cnt_inc >= TIMEOUT);

  assign grant_o      = grant_q;
  assign grant_idx_o  = gidx_q;
  assign err_master_o = err_master_q;
  assign bus_err_o    = bus_err_q;
  assign busy_o       = (state_q != ST_IDLE);

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      err_master_q <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      err_master_q <= err_master_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Next-state logic and the combinational handshake pass-throughs.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    err_master_d = err_master_q;
    bus_err_d    = 1'b0;
    m_req_rdy_o  = '0;
    m_rsp_vld_o  = '0;
    s_req_vld_o  = 1'b0;
    s_rsp_rdy_o  = 1'b0;
    err_rsp_o    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d  = pick_gnt;
          gidx_d   = pick_idx;
          rr_ptr_d = rr_next;
          state_d  = ST_REQ;
        end
      end

      ST_REQ: begin
        s_req_vld_o = g_req_vld;
        m_req_rdy_o = grant_q & {MASTER_NUM{s_req_rdy_i}};
        if (g_req_vld && s_req_rdy_i) begin
          cnt_d   = '0;
          state_d = ST_RSP;
        end else if (!g_req_vld) begin
          grant_d = '0;
          gidx_d  = '0;
          state_d = ST_IDLE;
        end
      end

      ST_RSP: begin
        m_rsp_vld_o = grant_q & {MASTER_NUM{s_rsp_vld_i}};
        s_rsp_rdy_o = g_rsp_rdy;
        if (s_rsp_vld_i && g_rsp_rdy) begin
          grant_d = '0;
          gidx_d  = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (wd_fire) begin
            bus_err_d    = 1'b1;
            err_master_d = gidx_q;
            state_d      = ST_ERR;
          end
        end
      end

      ST_ERR: begin
        // Synthesised error response; any late slave response is drained.
        m_rsp_vld_o = grant_q;
        err_rsp_o   = 1'b1;
        s_rsp_rdy_o = 1'b1;
        if (g_rsp_rdy) begin
          grant_d = '0;
          gidx_d  = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        grant_d = '0;
        gidx_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rib_arbiter.sv
// Self-checking bench for rib_arbiter: arbitration vector table with a grant
// scoreboard, plus hand-written watchdog, stall, abort and reset sequences.
module tb_rib_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] m_req_vld_i = '0;
  logic [3:0] m_req_rdy_o;
  logic [3:0] m_rsp_vld_o;
  logic [3:0] m_rsp_rdy_i = '0;
  logic       s_req_vld_o;
  logic       s_req_rdy_i = 1'b0;
  logic       s_rsp_vld_i = 1'b0;
  logic       s_rsp_rdy_o;
  logic [3:0] grant_o;
  logic [1:0] grant_idx_o;
  logic       err_rsp_o;
  logic       bus_err_o;
  logic [1:0] err_master_o;
  logic       busy_o;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
  } vec_t;

  vec_t vecs[12];

  rib_arbiter #(
    .MASTER_NUM   (4),
    .HI_PRIO_MASK (4'b0100),
    .TIMEOUT      (8'd8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .m_req_vld_i  (m_req_vld_i),
    .m_req_rdy_o  (m_req_rdy_o),
    .m_rsp_vld_o  (m_rsp_vld_o),
    .m_rsp_rdy_i  (m_rsp_rdy_i),
    .s_req_vld_o  (s_req_vld_o),
    .s_req_rdy_i  (s_req_rdy_i),
    .s_rsp_vld_i  (s_rsp_vld_i),
    .s_rsp_rdy_o  (s_rsp_rdy_o),
    .grant_o      (grant_o),
    .grant_idx_o  (grant_idx_o),
    .err_rsp_o    (err_rsp_o),
    .bus_err_o    (bus_err_o),
    .err_master_o (err_master_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Called at a negedge with the DUT idle: drive requests, expect the grant
  // one cycle later, popped from the scoreboard.
  task automatic grant_phase(input logic [3:0] mask, input logic [3:0] exp_gnt);
    logic [3:0] e;
    check("idle_before_req", 32'(busy_o), 0);
    m_req_vld_i = mask;
    exp_q.push_back(exp_gnt);
    @(negedge clk);
    e = exp_q.pop_front();
    check("grant", 32'(grant_o), 32'(e));
    check("grant_idx", 32'(grant_idx_o), 32'(oh2idx(e)));
    check("s_req_vld", 32'(s_req_vld_o), 1);
    check("req_rdy_idle_slave", 32'(m_req_rdy_o), 0);
  endtask

  // Request handshake; returns at the first negedge inside RSP.
  task automatic req_hs(input logic [3:0] e);
    s_req_rdy_i = 1'b1;
    #1;
    check("req_rdy_pass", 32'(m_req_rdy_o), 32'(e));
    @(negedge clk);
    s_req_rdy_i = 1'b0;
    check("rsp_entry_vld", 32'(m_rsp_vld_o), 0);
    check("rsp_entry_busy", 32'(busy_o), 1);
  endtask

  // Response handshake; returns at the following negedge (IDLE bubble).
  task automatic rsp_hs(input logic [3:0] e);
    s_rsp_vld_i = 1'b1;
    m_rsp_rdy_i = 4'hF;
    #1;
    check("rsp_vld_pass", 32'(m_rsp_vld_o), 32'(e));
    check("s_rsp_rdy", 32'(s_rsp_rdy_o), 1);
    @(negedge clk);
    s_rsp_vld_i = 1'b0;
    m_rsp_rdy_i = '0;
    check("bubble_busy", 32'(busy_o), 0);
    check("bubble_grant", 32'(grant_o), 0);
  endtask

  initial begin
    int k;
    vecs[0]  = '{4'b0010, 4'b0010};
    vecs[1]  = '{4'b1011, 4'b1000};
    vecs[2]  = '{4'b1011, 4'b0001};
    vecs[3]  = '{4'b1011, 4'b0010};
    vecs[4]  = '{4'b1011, 4'b1000};
    vecs[5]  = '{4'b0111, 4'b0100};
    vecs[6]  = '{4'b0011, 4'b0001};
    vecs[7]  = '{4'b1111, 4'b0100};
    vecs[8]  = '{4'b1001, 4'b1000};
    vecs[9]  = '{4'b0001, 4'b0001};
    vecs[10] = '{4'b1000, 4'b1000};
    vecs[11] = '{4'b0100, 4'b0100};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_grant", 32'(grant_o), 0);
    check("rst_grant_idx", 32'(grant_idx_o), 0);
    check("rst_err_master", 32'(err_master_o), 0);
    check("rst_outputs", 32'({m_req_rdy_o, m_rsp_vld_o, s_req_vld_o, s_rsp_rdy_o, err_rsp_o, bus_err_o}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Arbitration table: each record is one full minimum-length transaction.
    for (int i = 0; i < 12; i++) begin
      grant_phase(vecs[i].req, vecs[i].gnt);
      $display("txn %0d req=%b grant=%b idx=%0d", i, vecs[i].req, grant_o, grant_idx_o);
      req_hs(vecs[i].gnt);
      rsp_hs(vecs[i].gnt);
    end
    m_req_vld_i = '0;

    // Watchdog: m1, slave silent; error exactly 8 cycles after RSP entry.
    grant_phase(4'b0010, 4'b0010);
    req_hs(4'b0010);
    m_req_vld_i = '0;
    k = 0;
    while (!bus_err_o && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("wd_cycles", 32'(k), 8);
    check("wd_err_master", 32'(err_master_o), 1);
    check("wd_err_rsp", 32'(err_rsp_o), 1);
    check("wd_rsp_vld", 32'(m_rsp_vld_o), 32'(4'b0010));
    check("wd_s_rsp_rdy", 32'(s_rsp_rdy_o), 1);
    @(negedge clk);
    check("wd_pulse_end", 32'(bus_err_o), 0);
    check("wd_err_hold", 32'(err_rsp_o), 1);
    check("wd_vld_hold", 32'(m_rsp_vld_o), 32'(4'b0010));
    m_rsp_rdy_i = 4'b0010;
    @(negedge clk);
    m_rsp_rdy_i = '0;
    check("wd_idle", 32'(busy_o), 0);
    check("wd_err_rsp_clr", 32'(err_rsp_o), 0);
    check("wd_err_master_hold", 32'(err_master_o), 1);
    $display("txn wd master=1 cycles=%0d", k);

    // Master stalls response ready for 5 cycles (m3).
    grant_phase(4'b1000, 4'b1000);
    req_hs(4'b1000);
    m_req_vld_i = '0;
    s_rsp_vld_i = 1'b1;
    repeat (5) begin
      #1;
      check("stall_grant", 32'(grant_o), 32'(4'b1000));
      check("stall_s_rsp_rdy", 32'(s_rsp_rdy_o), 0);
      check("stall_rsp_vld", 32'(m_rsp_vld_o), 32'(4'b1000));
      check("stall_no_err", 32'(bus_err_o), 0);
      @(negedge clk);
    end
    rsp_hs(4'b1000);
    $display("txn stall master=3");

    // Response arrives in the watchdog limit cycle (m2): no error.
    grant_phase(4'b0100, 4'b0100);
    req_hs(4'b0100);
    m_req_vld_i = '0;
    repeat (7) @(negedge clk);
    check("edge_no_early_err", 32'(bus_err_o), 0);
    check("edge_still_rsp", 32'(err_rsp_o), 0);
    s_rsp_vld_i = 1'b1;
    m_rsp_rdy_i = 4'b0100;
    #1;
    check("edge_rsp_vld", 32'(m_rsp_vld_o), 32'(4'b0100));
    @(negedge clk);
    s_rsp_vld_i = 1'b0;
    m_rsp_rdy_i = '0;
    check("edge_no_err", 32'(bus_err_o), 0);
    check("edge_err_rsp", 32'(err_rsp_o), 0);
    check("edge_idle", 32'(busy_o), 0);
    $display("txn edge master=2");

    // Request dropped before handshake (m0): back to IDLE, grant cleared.
    grant_phase(4'b0001, 4'b0001);
    m_req_vld_i = '0;
    #1;
    check("abort_s_req_vld", 32'(s_req_vld_o), 0);
    @(negedge clk);
    check("abort_idle", 32'(busy_o), 0);
    check("abort_grant", 32'(grant_o), 0);
    check("abort_grant_idx", 32'(grant_idx_o), 0);
    $display("txn abort master=0");

    // Reset during RSP (m1 leaves rr_ptr at 2), then rr_ptr must restart at 0.
    grant_phase(4'b0010, 4'b0010);
    req_hs(4'b0010);
    m_req_vld_i = '0;
    s_rsp_vld_i = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_grant", 32'(grant_o), 0);
    check("mid_rst_outputs", 32'({m_req_rdy_o, m_rsp_vld_o, s_req_vld_o, s_rsp_rdy_o, err_rsp_o, bus_err_o}), 0);
    check("mid_rst_err_master", 32'(err_master_o), 0);
    rst = 1'b0;
    s_rsp_vld_i = 1'b0;
    @(negedge clk);
    grant_phase(4'b1001, 4'b0001);
    req_hs(4'b0001);
    rsp_hs(4'b0001);
    m_req_vld_i = '0;
    $display("txn post_reset grant=0001");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rib_arbiter.md
# rib_arbiter

Sequencing arbiter for the RIB interconnect: it shares one slave-side request/response channel between up to four bus masters (core ibus, core dbus, JTAG debug, spare). It performs round-robin arbitration with a high-priority override, holds a grant for one full transaction (request handshake, then response handshake), and drives the one-hot grant that steers the RIB address, data and sel muxes. A response watchdog converts a hung slave into an error response, so no master deadlocks the bus.

## Interface
- MASTER_NUM, 4: number of masters, 1..4; unused masters tie req_vld low.
- HI_PRIO_MASK, 4'b0100: masters that win over round-robin whenever requesting (JTAG, m2); ties among them go to the lowest index.
- TIMEOUT, 8'd255: response watchdog limit in cycles, 1..255; 0 disables the watchdog.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous active-high.
- m_req_vld_i  in  MASTER_NUM  per-master request valid.
- m_req_rdy_o  out  MASTER_NUM  per-master request ready.
- m_rsp_vld_o  out  MASTER_NUM  per-master response valid.
- m_rsp_rdy_i  in  MASTER_NUM  per-master response ready.
- s_req_vld_o  out  1  slave-side request valid.
- s_req_rdy_i  in  1  slave-side request ready.
- s_rsp_vld_i  in  1  slave-side response valid.
- s_rsp_rdy_o  out  1  slave-side response ready.
- grant_o  out  MASTER_NUM  one-hot grant; mux select for addr/data/sel/we.
- grant_idx_o  out  2  binary index of the granted master.
- err_rsp_o  out  1  high in ERR state; the RIB forces master read data to 0.
- bus_err_o  out  1  one-cycle pulse when the watchdog fires.
- err_master_o  out  2  index of the master that received the last error; holds until the next error.
- busy_o  out  1  state != IDLE.

## Operation
- States: IDLE, REQ, RSP, ERR. All state is registered.
- IDLE:
  - Any m_req_vld_i high: pick a winner. If any HI_PRIO_MASK master is requesting, take the lowest-index one. Otherwise round-robin starting at rr_ptr.
  - Register grant_o and grant_idx_o, set rr_ptr = (winner+1) mod MASTER_NUM, go to REQ.
- REQ:
  - s_req_vld_o = m_req_vld_i[g].
  - m_req_rdy_o[g] = s_req_rdy_i. All other m_req_rdy_o bits are 0.
  - Handshake (both high): clear the counter, go to RSP.
  - m_req_vld_i[g] drops before the handshake: go to IDLE, clear the grant.
- RSP:
  - m_rsp_vld_o[g] = s_rsp_vld_i.
  - s_rsp_rdy_o = m_rsp_rdy_i[g].
  - Handshake: go to IDLE, clear the grant.
  - Otherwise the counter increments each cycle. When the counter reaches TIMEOUT (TIMEOUT != 0): pulse bus_err_o, load err_master_o = g, go to ERR.
- ERR:
  - m_rsp_vld_o[g] = 1, err_rsp_o = 1, s_rsp_rdy_o = 1 (drains any late slave response).
  - On m_rsp_rdy_i[g]: go to IDLE.
- Grant never changes outside IDLE; non-granted masters see rdy/vld = 0.
- The counter is 8-bit and saturates; it cannot wrap.

## Timing
- Reset: state IDLE, grant_o 0, grant_idx_o 0, rr_ptr 0, counter 0, err_master_o 0. All other outputs 0.
- Reset mid-transaction: IDLE on the next edge; the pending response is discarded.
- Arbitration latency: request seen in IDLE at cycle N, grant and s_req_vld_o at N+1.
- REQ/RSP pass-throughs are combinational from the slave/master inputs to the outputs; there is no added cycle.
- Back-to-back: one IDLE bubble cycle between transactions. Minimum transaction is 3 cycles when the slave answers in the cycle after the request.
- Simultaneous requests: the high-priority master wins, else rr_ptr order. A master requesting continuously gets at most one grant per MASTER_NUM grants while others wait, the high-priority master excepted.
- Watchdog: bus_err_o asserts exactly TIMEOUT cycles after entering RSP with no s_rsp_vld_i.
- s_rsp_vld_i in the same cycle the counter hits TIMEOUT: the normal response wins; no error.

## Structure
- State encodings (2-bit) and TIMEOUT counter width go in defines.v, alongside the existing RIB constants.
- Sub-module rib_rr_pick: combinational picker. Inputs are req, rr_ptr and HI_PRIO_MASK; outputs are a one-hot grant and an index.

## Test plan
- Single master m1 requests, slave answers one cycle later: grant_o=4'b0010 at N+1, m_rsp_vld_o[1] pulses, busy_o low after the handshake.
- m0, m1, m3 requesting continuously, m2 idle: grants rotate 0,1,3,0,1,3; each grant is separated by one IDLE cycle.
- m2 asserts while m0/m1 are requesting: m2 is granted next, pre-empting rr order, but only after the current transaction completes.
- Slave never returns s_rsp_vld_i with TIMEOUT=8: bus_err_o pulses 8 cycles after RSP entry and err_master_o=g. err_rsp_o and m_rsp_vld_o[g] stay high until m_rsp_rdy_i, then IDLE.
- Master holds m_rsp_rdy_i low for 5 cycles while s_rsp_vld_i stays high: the grant holds and s_rsp_rdy_o stays 0 until ready.
- rst asserted during RSP: all outputs 0 at the next edge; a new request is granted from rr_ptr=0.
